// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W-bit operands (W = 4*NIBBLES) one 4-bit digit per clock, using an
//   external combinational 4-bit adder stage. The least significant digit is
//   processed first, and the carry ripples through a register between cycles.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              request; accepted only in IDLE
//   a, b, cin          operands and initial carry, latched when start is accepted
//   add_a, add_b       current digit pair sent to the external adder (0 outside RUN)
//   add_cin            current carry sent to the external adder (0 outside RUN)
//   add_s, add_cout    digit sum and carry returned by the external adder
//   sum, cout          registered result and final carry
//   busy               high while in RUN
//   done               one-cycle pulse in DONE
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned SH_W  = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    // Bit offset of the current digit: idx * 4.
    logic [SH_W-1:0]  shamt;
    logic [W-1:0]     a_shift;
    logic [W-1:0]     b_shift;
    logic [W-1:0]     digit_mask;

    assign shamt      = {idx_q, 2'b00};
    assign a_shift    = a_q >> shamt;
    assign b_shift    = b_q >> shamt;
    assign digit_mask = W'(4'hF) << shamt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; adder-stage drive comes straight from registers
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                add_a   = a_shift[3:0];
                add_b   = b_shift[3:0];
                add_cin = carry_q;
                busy    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: latch on accept, merge one digit per RUN cycle
    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~digit_mask) | (W'(add_s) << shamt);
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d = add_cout;
                    idx_d  = '0;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Directed bench for nibble_serial_adder with NIBBLES=4. The external 4-bit
//   adder stage is modelled here; outputs are sampled on the falling edge.
module tb_nibble_serial_adder;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int vectors;
    int miscompares;

    // External 4-bit adder stage
    logic [4:0] stage_sum;
    assign stage_sum = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    assign add_s     = stage_sum[3:0];
    assign add_cout  = stage_sum[4];

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge; returns on the falling edge of the first RUN cycle.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout got=%b exp=0", cout); end
        vectors++; if ({add_a, add_b, add_cin} !== 9'h000) begin
            miscompares++; $display("FAIL reset_adder_drive got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        launch(16'h1234, 16'h4321, 1'b0);
        vectors++; if (add_a !== 4'h4 || add_b !== 4'h1) begin
            miscompares++; $display("FAIL basic_digit0 got=%h/%h exp=4/1", add_a, add_b);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++; $display("FAIL basic_run%0d busy/done got=%b/%b exp=1/0", i, busy, done);
            end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_done busy/done got=%b/%b exp=0/1", busy, done);
        end
        vectors++; if (sum !== 16'h5555 || cout !== 1'b0) begin
            miscompares++; $display("FAIL basic_result got=%h/%b exp=5555/0", sum, cout);
        end
        vectors++; if ({add_a, add_b, add_cin} !== 9'h000) begin
            miscompares++; $display("FAIL basic_done_drive got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin);
        end
        @(negedge clk);
        vectors++; if (done !== 1'b0 || sum !== 16'h5555 || cout !== 1'b0) begin
            miscompares++; $display("FAIL basic_hold done/sum/cout got=%b/%h/%b exp=0/5555/0", done, sum, cout);
        end
    endtask

    task automatic test_ripple();
        launch(16'hFFFF, 16'h0001, 1'b0);
        repeat (4) @(negedge clk);
        vectors++; if (done !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
            miscompares++; $display("FAIL ripple done/sum/cout got=%b/%h/%b exp=1/0000/1", done, sum, cout);
        end
    endtask

    task automatic test_all_ones();
        launch(16'hFFFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (add_cin !== 1'b1 || busy !== 1'b1) begin
                miscompares++; $display("FAIL ones_run%0d add_cin/busy got=%b/%b exp=1/1", i, add_cin, busy);
            end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b1) begin
            miscompares++; $display("FAIL ones done/sum/cout got=%b/%h/%b exp=1/ffff/1", done, sum, cout);
        end
    endtask

    task automatic test_start_held();
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++; $display("FAIL held_run%0d busy/done got=%b/%b exp=1/0", i, busy, done);
            end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || sum !== 16'h3333 || cout !== 1'b0) begin
            miscompares++; $display("FAIL held_result done/sum/cout got=%b/%h/%b exp=1/3333/0", done, sum, cout);
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL held_idle busy/done got=%b/%b exp=0/0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        vectors++; if (busy !== 1'b1 || sum !== 16'h0000) begin
            miscompares++; $display("FAIL held_restart busy/sum got=%b/%h exp=1/0000", busy, sum);
        end
        repeat (4) @(negedge clk);
        vectors++; if (done !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
            miscompares++; $display("FAIL held_second done/sum/cout got=%b/%h/%b exp=1/0000/1", done, sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        launch(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL abort busy/done/sum/cout got=%b/%b/%h/%b exp=0/0/0000/0", busy, done, sum, cout);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0 || sum !== 16'h0000) begin
            miscompares++; $display("FAIL abort_quiet activity/sum got=%b/%h exp=0/0000", saw_done, sum);
        end
    endtask

    task automatic test_back_to_back();
        launch(16'h0001, 16'h0001, 1'b0);
        repeat (4) @(negedge clk);
        vectors++; if (done !== 1'b1 || sum !== 16'h0002 || cout !== 1'b0) begin
            miscompares++; $display("FAIL b2b_first done/sum/cout got=%b/%h/%b exp=1/0002/0", done, sum, cout);
        end
        launch(16'h8000, 16'h8000, 1'b0);
        vectors++; if (sum !== 16'h0000 || busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_clear sum/busy got=%h/%b exp=0000/1", sum, busy);
        end
        repeat (4) @(negedge clk);
        vectors++; if (done !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
            miscompares++; $display("FAIL b2b_second done/sum/cout got=%b/%h/%b exp=1/0000/1", done, sum, cout);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_ripple();
        test_all_ones();
        test_start_held();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
